// File: rtl/pipe_field_controller.sv
// -----------------------------------------------------------------------------
// pipe_field_controller
//
// Game controller for a scrolling-pipe game. It runs the IDLE/PLAY/GAME_OVER
// state machine and scrolls NUM_PIPES obstacle pipes from right to left. When a
// pipe leaves the screen it is moved back to the right and gets a new random gap
// centre taken from a 10-bit LFSR. The block detects collisions of the bird with
// a pipe or with the screen floor, and keeps a saturating count of pipes passed.
//
// Ports
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   tick         : one-cycle frame strobe; pipes move and the score changes
//                  only on a tick
//   start_button : debounced start level
//   bird_y       : top edge of the bird, px
//   pipe_x       : left edge of pipe i at [11*i +: 11]
//   pipe_gap_y   : gap centre of pipe i at [10*i +: 10]
//   state        : 00 IDLE, 01 PLAY, 10 GAME_OVER
//   collision    : high from the hit tick until the FSM leaves GAME_OVER
//   score        : pipes passed, saturating
// -----------------------------------------------------------------------------
module pipe_field_controller #(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          NUM_PIPES     = 3,
  parameter int          PIPE_WIDTH    = 30,
  parameter int          PIPE_GAP      = 100,
  parameter int          PIPE_SPACING  = 220,
  parameter int          SCROLL_STEP   = 4,
  parameter int          BIRD_X        = 200,
  parameter int          BIRD_WIDTH    = 20,
  parameter int          BIRD_HEIGHT   = 20,
  parameter int          SCORE_WIDTH   = 8,
  parameter logic [9:0]  LFSR_SEED     = 10'h2A5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start_button,
  input  logic [9:0]               bird_y,
  output logic [11*NUM_PIPES-1:0]  pipe_x,
  output logic [10*NUM_PIPES-1:0]  pipe_gap_y,
  output logic [1:0]               state,
  output logic                     collision,
  output logic [SCORE_WIDTH-1:0]   score
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PLAY      = 2'b01,
    S_GAME_OVER = 2'b10
  } state_e;

  // All collision/pass geometry is evaluated on 12 bits so no sum can wrap.
  localparam logic [11:0] BIRD_X_12   = 12'(BIRD_X);
  localparam logic [11:0] BIRD_W_12   = 12'(BIRD_WIDTH);
  localparam logic [11:0] BIRD_H_12   = 12'(BIRD_HEIGHT);
  localparam logic [11:0] SCREEN_H_12 = 12'(SCREEN_HEIGHT);
  localparam logic [11:0] PIPE_W_12   = 12'(PIPE_WIDTH);
  localparam logic [11:0] HALF_GAP_12 = 12'(PIPE_GAP / 2);
  localparam logic [11:0] STEP_12     = 12'(SCROLL_STEP);

  localparam logic [10:0] STEP_11     = 11'(SCROLL_STEP);
  // Respawn keeps the spacing: x - step + NUM_PIPES*spacing, folded into one add.
  localparam logic [10:0] RESPAWN_11  = 11'(NUM_PIPES * PIPE_SPACING - SCROLL_STEP);

  localparam logic [9:0]  GAP_MIN     = 10'(PIPE_GAP / 2);
  localparam logic [9:0]  GAP_MAX     = 10'(SCREEN_HEIGHT - PIPE_GAP / 2 - 1);
  localparam logic [9:0]  GAP_HOME    = 10'(SCREEN_HEIGHT / 2);

  localparam int          CNT_W       = $clog2(NUM_PIPES + 1);
  localparam int          SUM_W       = SCORE_WIDTH + CNT_W + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = {SCORE_WIDTH{1'b1}};

  function automatic logic [10:0] x_home(input int idx);
    return 11'(SCREEN_WIDTH + idx * PIPE_SPACING);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,       state_d;
  logic [10:0]             x_q   [NUM_PIPES];
  logic [10:0]             x_d   [NUM_PIPES];
  logic [9:0]              gap_q [NUM_PIPES];
  logic [9:0]              gap_d [NUM_PIPES];
  logic [SCORE_WIDTH-1:0]  score_q,       score_d;
  logic                    collision_q,   collision_d;
  logic [9:0]              lfsr_q,        lfsr_d;
  logic                    start_prev_q,  start_prev_d;

  logic                    hit;
  logic [NUM_PIPES-1:0]    pass;
  logic [9:0]              new_gap;
  logic [SUM_W-1:0]        pass_cnt;
  logic [SUM_W-1:0]        score_sum;
  logic [SCORE_WIDTH-1:0]  score_next;

  // ---------------------------------------------------------------------------
  // LFSR and gap draw: x^10 + x^7 + 1, free-running in every state.
  // ---------------------------------------------------------------------------
  assign lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  assign start_prev_d = start_button;

  always_comb begin
    if (lfsr_q < GAP_MIN)      new_gap = GAP_MIN;
    else if (lfsr_q > GAP_MAX) new_gap = GAP_MAX;
    else                       new_gap = lfsr_q;
  end

  // ---------------------------------------------------------------------------
  // Collision and pass detection from the current registers (before motion).
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed; the clocked block uses '<=' so every flop samples the
  // pre-edge values together.
  always_comb begin
    hit = (12'(bird_y) + BIRD_H_12) > SCREEN_H_12;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if ((BIRD_X_12 + BIRD_W_12 > 12'(x_q[i])) &&
          (BIRD_X_12 < 12'(x_q[i]) + PIPE_W_12) &&
          ((12'(bird_y) < 12'(gap_q[i]) - HALF_GAP_12) ||
           (12'(bird_y) + BIRD_H_12 > 12'(gap_q[i]) + HALF_GAP_12))) begin
        hit = 1'b1;
      end
    end
  end

  // A pipe is passed on the tick its right edge crosses from right of BIRD_X to
  // at-or-left of it; the step is moved to the right-hand side to avoid wrap.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pass[i]  = (12'(x_q[i]) + PIPE_W_12 > BIRD_X_12) &&
                 (12'(x_q[i]) + PIPE_W_12 <= BIRD_X_12 + STEP_12);
      pass_cnt = pass_cnt + SUM_W'(pass[i]);
    end
    score_sum  = SUM_W'(score_q) + pass_cnt;
    score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                 : score_sum[SCORE_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    gap_d       = gap_q;
    score_d     = score_q;
    collision_d = collision_q;

    unique case (state_q)
      S_IDLE: begin
        // The start cycle itself never moves pipes, even with tick high.
        if (start_button) state_d = S_PLAY;
      end

      S_PLAY: begin
        if (tick) begin
          if (hit) begin
            state_d     = S_GAME_OVER;
            collision_d = 1'b1;
          end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              if (x_q[i] >= STEP_11) begin
                x_d[i] = x_q[i] - STEP_11;
              end else begin
                x_d[i]   = x_q[i] + RESPAWN_11;
                gap_d[i] = new_gap;
              end
            end
            score_d = score_next;
          end
        end
      end

      S_GAME_OVER: begin
        if (start_button && !start_prev_q) begin
          state_d     = S_IDLE;
          score_d     = '0;
          collision_d = 1'b0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i]   = x_home(i);
            gap_d[i] = GAP_HOME;
          end
        end
      end

      default: begin
        // Unreachable encoding 2'b11: recover to a clean IDLE field.
        state_d     = S_IDLE;
        score_d     = '0;
        collision_d = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
          x_d[i]   = x_home(i);
          gap_d[i] = GAP_HOME;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the per-pipe arrays are a handful of flops, not a RAM, so they are
  // reset together with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      score_q      <= '0;
      collision_q  <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      start_prev_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_home(i);
        gap_q[i] <= GAP_HOME;
      end
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      collision_q  <= collision_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= start_prev_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
    assign pipe_x[11*g +: 11]     = x_q[g];
    assign pipe_gap_y[10*g +: 10] = gap_q[g];
  end

  assign state     = state_q;
  assign collision = collision_q;
  assign score     = score_q;

endmodule

// File: tb/tb_pipe_field_controller.sv
// -----------------------------------------------------------------------------
// tb_pipe_field_controller
//
// Directed bench for pipe_field_controller. Stimulus pushes hand-computed
// expectations, tagged with the cycle they apply to, into a scoreboard queue;
// a monitor samples the DUT on the falling edge and pops/compares them.
// A second instance with a 1-bit score shares the stimulus to exercise score
// saturation.
// -----------------------------------------------------------------------------
module tb_pipe_field_controller;

  localparam int NP = 3;

  logic              clk;
  logic              reset;
  logic              tick;
  logic              start_button;
  logic [9:0]        bird_y;
  logic [11*NP-1:0]  pipe_x;
  logic [10*NP-1:0]  pipe_gap_y;
  logic [1:0]        state;
  logic              collision;
  logic [7:0]        score;

  logic [11*NP-1:0]  sat_pipe_x;
  logic [10*NP-1:0]  sat_pipe_gap_y;
  logic [1:0]        sat_state;
  logic              sat_collision;
  logic [0:0]        sat_score;

  pipe_field_controller dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_button (start_button),
    .bird_y       (bird_y),
    .pipe_x       (pipe_x),
    .pipe_gap_y   (pipe_gap_y),
    .state        (state),
    .collision    (collision),
    .score        (score)
  );

  pipe_field_controller #(.SCORE_WIDTH(1)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_button (start_button),
    .bird_y       (bird_y),
    .pipe_x       (sat_pipe_x),
    .pipe_gap_y   (sat_pipe_gap_y),
    .state        (sat_state),
    .collision    (sat_collision),
    .score        (sat_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef enum int {K_STATE, K_X, K_GAP, K_SCORE, K_COLL, K_SAT} kind_e;

  typedef struct {
    string name;
    int    cyc;
    kind_e kind;
    int    idx;
    int    lo;
    int    hi;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
      else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int actual_of(input exp_t e);
    case (e.kind)
      K_STATE: return int'(state);
      K_X:     return int'(pipe_x[11*e.idx +: 11]);
      K_GAP:   return int'(pipe_gap_y[10*e.idx +: 10]);
      K_SCORE: return int'(score);
      K_COLL:  return int'(collision);
      K_SAT:   return int'(sat_score);
      default: return -1;
    endcase
  endfunction

  // Expectation for the outputs after the next rising edge.
  task automatic exp_rng(input string name, input kind_e k, input int idx, input int lo, input int hi);
    exp_t e;
    e.name = name;
    e.cyc  = cycle + 1;
    e.kind = k;
    e.idx  = idx;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  task automatic exp_eq(input string name, input kind_e k, input int idx, input int v);
    exp_rng(name, k, idx, v, v);
  endtask

  task automatic step(input logic rst, input logic tk, input logic st, input logic [9:0] by);
    reset        = rst;
    tick         = tk;
    start_button = st;
    bird_y       = by;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n, input logic [9:0] by);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, by);
  endtask

  task automatic exp_home(input string tag);
    exp_eq({tag, "_state"}, K_STATE, 0, 0);
    exp_eq({tag, "_x0"},    K_X,     0, 640);
    exp_eq({tag, "_x1"},    K_X,     1, 860);
    exp_eq({tag, "_x2"},    K_X,     2, 1080);
    exp_eq({tag, "_gap0"},  K_GAP,   0, 240);
    exp_eq({tag, "_gap1"},  K_GAP,   1, 240);
    exp_eq({tag, "_gap2"},  K_GAP,   2, 240);
    exp_eq({tag, "_score"}, K_SCORE, 0, 0);
    exp_eq({tag, "_coll"},  K_COLL,  0, 0);
  endtask

  // Monitor: compares every expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        if (e.cyc < cycle) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: sample for cycle %0d taken at cycle %0d", e.name, e.cyc, cycle);
        end else begin
          check(e.name, actual_of(e), e.lo, e.hi);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset        = 1'b1;
    tick         = 1'b0;
    start_button = 1'b0;
    bird_y       = 10'd230;

    // Reset values.
    exp_home("rst");
    exp_eq("rst_sat_score", K_SAT, 0, 0);
    step(1'b1, 1'b0, 0, 10'd230);

    exp_eq("idle_hold", K_STATE, 0, 0);
    step(1'b0, 1'b0, 0, 10'd230);

    // Start with tick high: PLAY, but no motion in that cycle.
    exp_eq("start_state", K_STATE, 0, 1);
    exp_eq("start_nomove_x0", K_X, 0, 640);
    step(1'b0, 1'b1, 1'b1, 10'd230);

    // Ten ticks: 640 -> 600.
    run_ticks(9, 10'd230);
    exp_eq("t10_x0", K_X, 0, 600);
    exp_eq("t10_x1", K_X, 1, 820);
    exp_eq("t10_x2", K_X, 2, 1040);
    exp_eq("t10_coll", K_COLL, 0, 0);
    exp_eq("t10_state", K_STATE, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Pipe 0 crosses the bird: 176 -> 172 (no pass), 172 -> 168 (pass).
    run_ticks(106, 10'd230);
    exp_eq("pre_pass_x0", K_X, 0, 172);
    exp_eq("pre_pass_score", K_SCORE, 0, 0);
    step(1'b0, 1'b1, 1'b0, 10'd230);
    exp_eq("pass0_x0", K_X, 0, 168);
    exp_eq("pass0_score", K_SCORE, 0, 1);
    exp_eq("pass0_sat", K_SAT, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Pipe 0 reaches 0, then respawns at 656 with a new gap.
    run_ticks(41, 10'd230);
    exp_eq("edge_x0", K_X, 0, 0);
    step(1'b0, 1'b1, 1'b0, 10'd230);
    exp_eq("respawn_x0", K_X, 0, 656);
    exp_eq("respawn_x1", K_X, 1, 216);
    exp_eq("respawn_x2", K_X, 2, 436);
    exp_rng("respawn_gap0", K_GAP, 0, 50, 429);
    exp_eq("respawn_gap1", K_GAP, 1, 240);
    exp_eq("respawn_score", K_SCORE, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Pipe 1 passes: main score 2, 1-bit score saturates at 1.
    run_ticks(10, 10'd230);
    exp_eq("pre_pass1_x1", K_X, 1, 172);
    step(1'b0, 1'b1, 1'b0, 10'd230);
    exp_eq("pass1_x1", K_X, 1, 168);
    exp_eq("pass1_score", K_SCORE, 0, 2);
    exp_eq("pass1_sat", K_SAT, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Advance until pipe 2 overlaps the bird; pipe 1 respawns on the way.
    run_ticks(42, 10'd230);
    exp_eq("ovl_x2", K_X, 2, 216);
    exp_eq("ovl_x1", K_X, 1, 656);
    exp_eq("ovl_x0", K_X, 0, 436);
    exp_eq("ovl_coll", K_COLL, 0, 0);
    exp_eq("ovl_state", K_STATE, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Bird above the gap while overlapping pipe 2: GAME_OVER, field frozen.
    exp_eq("hit_state", K_STATE, 0, 2);
    exp_eq("hit_coll", K_COLL, 0, 1);
    exp_eq("hit_x2", K_X, 2, 216);
    exp_eq("hit_x0", K_X, 0, 436);
    exp_eq("hit_score", K_SCORE, 0, 2);
    step(1'b0, 1'b1, 1'b0, 10'd100);
    exp_eq("go_hold_state", K_STATE, 0, 2);
    exp_eq("go_hold_x2", K_X, 2, 216);
    exp_eq("go_hold_x1", K_X, 1, 656);
    step(1'b0, 1'b1, 1'b0, 10'd100);

    // Start rising edge: back to IDLE with the home field.
    exp_home("restart");
    step(1'b0, 1'b0, 1'b1, 10'd230);
    exp_eq("restart_play", K_STATE, 0, 1);
    step(1'b0, 1'b0, 1'b1, 10'd230);

    // Floor boundary: bird_y=460 touches but does not cross the floor.
    exp_eq("floor460_state", K_STATE, 0, 1);
    exp_eq("floor460_coll", K_COLL, 0, 0);
    exp_eq("floor460_x0", K_X, 0, 636);
    step(1'b0, 1'b1, 1'b1, 10'd460);
    exp_eq("floor_notick_state", K_STATE, 0, 1);
    exp_eq("floor_notick_x0", K_X, 0, 636);
    step(1'b0, 1'b0, 1'b1, 10'd465);
    exp_eq("floor_state", K_STATE, 0, 2);
    exp_eq("floor_coll", K_COLL, 0, 1);
    exp_eq("floor_x0", K_X, 0, 636);
    step(1'b0, 1'b1, 1'b1, 10'd465);

    // Start held high is not a rising edge; only a fresh 0->1 restarts.
    exp_eq("go_level_state", K_STATE, 0, 2);
    step(1'b0, 1'b0, 1'b1, 10'd465);
    exp_eq("go_low_state", K_STATE, 0, 2);
    step(1'b0, 1'b0, 1'b0, 10'd230);
    exp_eq("rise_state", K_STATE, 0, 0);
    exp_eq("rise_score", K_SCORE, 0, 0);
    exp_eq("rise_coll", K_COLL, 0, 0);
    exp_eq("rise_x0", K_X, 0, 640);
    step(1'b0, 1'b0, 1'b1, 10'd230);
    exp_eq("replay_state", K_STATE, 0, 1);
    step(1'b0, 1'b0, 1'b1, 10'd230);
    exp_eq("replay_t1_x0", K_X, 0, 636);
    step(1'b0, 1'b1, 1'b0, 10'd230);
    exp_eq("replay_t2_x0", K_X, 0, 632);
    exp_eq("replay_t2_state", K_STATE, 0, 1);
    step(1'b0, 1'b1, 1'b0, 10'd230);

    // Reset mid-PLAY with tick and start high: reset wins.
    exp_home("midrst");
    step(1'b1, 1'b1, 1'b1, 10'd230);
    step(1'b0, 1'b0, 1'b0, 10'd230);

    stim_done = 1'b1;
  end

  // Summary
  initial begin
    wait (stim_done);
    repeat (3) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never sampled, expected %0d", e.name, e.lo);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
